cp0_exc_ctrl: RTL

- Coprocessor-0 exception/interrupt controller in the M stage of the 5-stage MIPS pipeline.
- Produces the redirect controls consumed by next-PC selection:
  - `req`: take exception or interrupt; fetch redirects to the handler entry `EXC_INIT`.
  - `eret_o`: return from exception.
  - `epc_o`: return address.
- Holds SR(12), Cause(13) and EPC(14), and services mfc0/mtc0.

---
 rtl/cp0_exc_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 SR/Cause/EPC with M-stage exception/interrupt redirect
// Optional: define CP0_PRID_EN for a read-only PRId at register 15.
module cp0_exc_ctrl #(
  parameter logic [5:0] IM_RST = 6'h00,
  parameter logic       IE_RST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code_m,
  input  logic [5:0]  hwint,
  input  logic        eret_m,
  output logic        req,
  output logic        eret_o,
  output logic [31:0] epc_o
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
`ifdef CP0_PRID_EN
  localparam logic [4:0]  ADDR_PRID = 5'd15;
  localparam logic [31:0] PRID_VAL  = 32'h0B0A_2024;
`endif

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr;
  logic [31:0] cause;

  // Interrupts look at the live lines, not the sampled IP copy.
  assign int_req = (|(hwint & im_q)) & ie_q & ~exl_q;
  assign exc_req = (exc_code_m != 5'd0) & ~exl_q;
  assign req     = int_req | exc_req;
  assign eret_o  = eret_m & ~req;
  assign epc_o   = epc_q;

  assign sr    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = hwint;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;

    if (we && !req) begin
      if (addr == ADDR_SR) begin
        im_d  = wdata[15:10];
        exl_d = wdata[1];
        ie_d  = wdata[0];
      end
      if (addr == ADDR_EPC) begin
        epc_d = wdata;
      end
    end

    if (eret_o) begin
      exl_d = 1'b0;
    end

    // A taken request squashes the M-stage instruction, so it overrides everything.
    if (req) begin
      exl_d      = 1'b1;
      exc_code_d = int_req ? 5'd0 : exc_code_m;
      bd_d       = bd_m;
      epc_d      = bd_m ? (pc_m - 32'd4) : pc_m;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      ADDR_SR:    rdata = sr;
      ADDR_CAUSE: rdata = cause;
      ADDR_EPC:   rdata = epc_q;
`ifdef CP0_PRID_EN
      ADDR_PRID:  rdata = PRID_VAL;
`endif
      default:    rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_q       <= IM_RST;
      exl_q      <= 1'b0;
      ie_q       <= IE_RST;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

endmodule
